// File: rtl/dac_serial_tx.sv
// dac_serial_tx: frames a signed DAC sample as offset binary with control bits and shifts it out SPI-style
module dac_serial_tx #(
   parameter int          DAC_DATA_WIDTH   = 12,
   parameter int          FRAME_BITS       = 16,
   parameter logic [31:0] CTRL_VALUE       = 32'd0,
   parameter int          CLK_DIV          = 2,
   parameter int          SYNC_HIGH_CYCLES = 2,
   parameter int          OVERRUN_BITS     = 8
) (
   input  logic                             CLK,
   input  logic                             RESET,
   input  logic                             CE,
   input  logic signed [DAC_DATA_WIDTH-1:0] DAC_VALUE,
   input  logic                             DAC_VALUE_WE,
   output logic                             DAC_SYNC_N,
   output logic                             DAC_SCLK,
   output logic                             DAC_SDIN,
   output logic                             BUSY,
   output logic [OVERRUN_BITS-1:0]          OVERRUN_COUNT
);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int BW = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
   localparam int GW = SYNC_HIGH_CYCLES > 1 ? $clog2(SYNC_HIGH_CYCLES) : 1;
   localparam int MSB = DAC_DATA_WIDTH - 1;
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
   state_t                    state;
   logic [DAC_DATA_WIDTH-1:0] hold;
   logic                      hold_valid;
   logic [FRAME_BITS-1:0]     shreg;
   logic [FRAME_BITS-1:0]     frame_word;
   logic [BW-1:0]             bit_cnt;
   logic [DW-1:0]             div_cnt;
   logic [GW-1:0]             gap_cnt;
   logic                      wr;
   logic                      consume;
   logic                      hv_next;
   assign wr         = CE & DAC_VALUE_WE;
   assign consume    = (state == IDLE) & hold_valid;
   assign hv_next    = wr | (hold_valid & ~consume);
   assign frame_word = (FRAME_BITS'(CTRL_VALUE) << DAC_DATA_WIDTH)
                     | FRAME_BITS'({~hold[MSB], hold[MSB-1:0]});
   // holding register, overrun counter and frame sequencer; SCLK doubles as the bit phase flag
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state         <= IDLE;
         hold          <= '0;
         hold_valid    <= 1'b0;
         shreg         <= '0;
         bit_cnt       <= '0;
         div_cnt       <= '0;
         gap_cnt       <= '0;
         DAC_SYNC_N    <= 1'b1;
         DAC_SCLK      <= 1'b1;
         DAC_SDIN      <= 1'b0;
         BUSY          <= 1'b0;
         OVERRUN_COUNT <= '0;
      end else begin
         hold_valid <= hv_next;
         if (wr)
            hold <= DAC_VALUE;
         if (wr && hold_valid && !consume && OVERRUN_COUNT != '1)
            OVERRUN_COUNT <= OVERRUN_COUNT + 1'b1;
         unique case (state)
            IDLE: begin
               if (hold_valid) begin
                  state      <= SHIFT;
                  shreg      <= frame_word << 1;
                  DAC_SDIN   <= frame_word[FRAME_BITS-1];
                  DAC_SYNC_N <= 1'b0;
                  DAC_SCLK   <= 1'b1;
                  bit_cnt    <= '0;
                  div_cnt    <= '0;
                  BUSY       <= 1'b1;
               end else begin
                  BUSY <= wr;
               end
            end
            SHIFT: begin
               BUSY <= 1'b1;
               if (div_cnt != DW'(CLK_DIV - 1)) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  if (DAC_SCLK) begin
                     DAC_SCLK <= 1'b0;
                  end else if (bit_cnt == BW'(FRAME_BITS - 1)) begin
                     state      <= GAP;
                     gap_cnt    <= '0;
                     DAC_SYNC_N <= 1'b1;
                     DAC_SCLK   <= 1'b1;
                     DAC_SDIN   <= 1'b0;
                  end else begin
                     bit_cnt  <= bit_cnt + 1'b1;
                     DAC_SCLK <= 1'b1;
                     DAC_SDIN <= shreg[FRAME_BITS-1];
                     shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GW'(SYNC_HIGH_CYCLES - 1)) begin
                  state <= IDLE;
                  BUSY  <= hv_next;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
                  BUSY    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
